// File: rtl/datapath_pkg.sv
// datapath_pkg: shared FIFO depth and select encodings for the buffered demux
package datapath_pkg;
  localparam int FIFO_DEPTH = 2;
  localparam logic SEL_SINK1 = 1'b0;
  localparam logic SEL_SINK2 = 1'b1;
endpackage

// File: rtl/demux_slot_fifo.sv
// demux_slot_fifo: 2-entry registered FIFO (push/pushData in, pop in, count/valid/head out)
module demux_slot_fifo
  import datapath_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [n-1:0] pushData,
  input  logic         pop,
  output logic [1:0]   count,
  output logic         valid,
  output logic [n-1:0] head
);
  logic [n-1:0] mem [FIFO_DEPTH];
  logic wr_ptr, rd_ptr, pop_eff;
  assign valid = count != 2'd0;
  assign head = mem[rd_ptr];
  assign pop_eff = pop && valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= pushData;
        wr_ptr <= !wr_ptr;
      end
      if (pop_eff) rd_ptr <= !rd_ptr;
      count <= (push && !pop_eff) ? count + 2'd1 : (!push && pop_eff) ? count - 2'd1 : count;
    end
  end
endmodule

// File: rtl/demux1to2_buf.sv
// demux1to2_buf: 1-to-2 buffered demux; select/inValid/dataIn/inReady in, per-sink outValid/dataOut/outReady via 2-entry FIFOs
module demux1to2_buf
  import datapath_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         select,
  input  logic         inValid,
  input  logic [n-1:0] dataIn,
  output logic         inReady,
  output logic         outValid1,
  output logic [n-1:0] dataOut1,
  input  logic         outReady1,
  output logic         outValid2,
  output logic [n-1:0] dataOut2,
  input  logic         outReady2
);
  logic [1:0] count1, count2;
  logic push1, push2;
  assign inReady = (select == SEL_SINK2 ? count2 : count1) < 2'(FIFO_DEPTH);
  assign push1 = inValid && inReady && select == SEL_SINK1;
  assign push2 = inValid && inReady && select == SEL_SINK2;
  demux_slot_fifo #(.n(n)) u_fifo1 (
    .clk(clk), .rst(rst), .push(push1), .pushData(dataIn), .pop(outReady1),
    .count(count1), .valid(outValid1), .head(dataOut1)
  );
  demux_slot_fifo #(.n(n)) u_fifo2 (
    .clk(clk), .rst(rst), .push(push2), .pushData(dataIn), .pop(outReady2),
    .count(count2), .valid(outValid2), .head(dataOut2)
  );
endmodule

// File: tb/tb_demux1to2_buf.sv
// tb_demux1to2_buf: directed self-checking bench for demux1to2_buf
module tb_demux1to2_buf;
  logic clk = 1'b0;
  logic rst, select, inValid, inReady, outValid1, outReady1, outValid2, outReady2;
  logic [31:0] dataIn, dataOut1, dataOut2;
  int n_assert = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  demux1to2_buf #(.n(32)) dut (
    .clk(clk), .rst(rst), .select(select), .inValid(inValid), .dataIn(dataIn),
    .inReady(inReady), .outValid1(outValid1), .dataOut1(dataOut1), .outReady1(outReady1),
    .outValid2(outValid2), .dataOut2(dataOut2), .outReady2(outReady2)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    int sent, rcv;
    bit pushing, popping;
    rst = 1; select = 0; inValid = 1; dataIn = 32'hDEADBEEF; outReady1 = 0; outReady2 = 0;
    tick();
    tick();
    chk("rst_ov1", 32'(outValid1), 0);
    chk("rst_ov2", 32'(outValid2), 0);
    chk("rst_d1", dataOut1, 0);
    chk("rst_d2", dataOut2, 0);
    chk("rst_inready", 32'(inReady), 1);
    rst = 0; inValid = 0;
    tick();
    chk("post_rst_ov1", 32'(outValid1), 0);
    chk("post_rst_ov2", 32'(outValid2), 0);
    outReady1 = 1; outReady2 = 1; select = 0; inValid = 1; dataIn = 32'h11;
    #1;
    chk("route_inready", 32'(inReady), 1);
    tick();
    chk("route_ov1", 32'(outValid1), 1);
    chk("route_d1", dataOut1, 32'h11);
    chk("route_ov2_idle", 32'(outValid2), 0);
    select = 1; dataIn = 32'h22;
    tick();
    chk("route_ov1_once", 32'(outValid1), 0);
    chk("route_ov2", 32'(outValid2), 1);
    chk("route_d2", dataOut2, 32'h22);
    inValid = 0;
    tick();
    chk("route_ov2_once", 32'(outValid2), 0);
    outReady1 = 0; outReady2 = 0; select = 0; inValid = 1; dataIn = 32'hA0;
    tick();
    dataIn = 32'hA1;
    tick();
    dataIn = 32'hA2;
    #1;
    chk("full_inready0", 32'(inReady), 0);
    select = 1;
    #1;
    chk("full_switch_inready", 32'(inReady), 1);
    tick();
    chk("full_ov2", 32'(outValid2), 1);
    chk("full_d2", dataOut2, 32'hA2);
    chk("full_d1_head", dataOut1, 32'hA0);
    inValid = 0; outReady1 = 1; outReady2 = 1;
    tick();
    chk("drain_ov1", 32'(outValid1), 1);
    chk("drain_d1", dataOut1, 32'hA1);
    chk("drain_ov2", 32'(outValid2), 0);
    tick();
    chk("drain_empty", 32'(outValid1), 0);
    outReady1 = 0; outReady2 = 0; select = 0; inValid = 1; dataIn = 32'h5;
    tick();
    chk("pp_d1_first", dataOut1, 32'h5);
    dataIn = 32'h6; outReady1 = 1;
    tick();
    chk("pp_ov1", 32'(outValid1), 1);
    chk("pp_d1", dataOut1, 32'h6);
    inValid = 0;
    tick();
    chk("pp_count1", 32'(outValid1), 0);
    outReady1 = 0; select = 1; sent = 0; rcv = 0;
    for (int c = 0; c < 60 && rcv < 10; c++) begin
      outReady2 = c[0];
      inValid = sent < 10;
      dataIn = 32'(sent);
      #1;
      pushing = inValid && inReady;
      popping = outValid2 && outReady2;
      if (popping) begin
        chk("wrap_data", dataOut2, 32'(rcv));
        rcv++;
      end
      if (pushing) sent++;
      tick();
    end
    chk("wrap_count", 32'(rcv), 10);
    inValid = 0; outReady2 = 0;
    tick();
    chk("wrap_nodup", 32'(outValid2), 0);
    inValid = 1; select = 0; dataIn = 32'hB0;
    tick();
    dataIn = 32'hB1;
    tick();
    select = 1; dataIn = 32'hC0;
    tick();
    dataIn = 32'hC1;
    tick();
    inValid = 0; select = 0;
    #1;
    chk("mid_full1", 32'(inReady), 0);
    select = 1;
    #1;
    chk("mid_full2", 32'(inReady), 0);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_ov1", 32'(outValid1), 0);
    chk("mid_ov2", 32'(outValid2), 0);
    inValid = 1; select = 0; dataIn = 32'h77;
    tick();
    chk("mid_new_d1", dataOut1, 32'h77);
    select = 1; dataIn = 32'h88; outReady1 = 1;
    tick();
    chk("mid_new_d2", dataOut2, 32'h88);
    chk("mid_no_old1", 32'(outValid1), 0);
    inValid = 0; outReady2 = 1;
    tick();
    chk("mid_no_old2", 32'(outValid2), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
